div_i16: RTL

Iterative 16-bit signed/unsigned integer divider, the inverse-operation companion to the 16-bit Booth multiplier in the integer ALU. It accepts dividend and divisor through a valid/ready handshake and computes one quotient bit per cycle with a radix-2 restoring algorithm on operand magnitudes. It applies sign correction in a final cycle and holds the quotient and remainder until the consumer accepts them. It sits beside the multiplier in the integer execution datapath and is shared by signed and unsigned divide and remainder operations.

---
 rtl/div_i16.sv | 135 +++++++++++++
 1 files changed

// File: rtl/div_i16.sv
// rtl/div_i16.sv - iterative 16-bit signed/unsigned radix-2 restoring divider
// Optional build macro DIV_I16_EARLY_OUT_EN: divide-by-zero, overflow and |a|<|b| bypass CALC.
module div_i16 (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        is_signed_i,
    input  logic        data_vld_i,
    output logic        data_rdy_o,
    output logic        data_vld_o,
    input  logic        data_rdy_i,
    output logic [15:0] q_o,
    output logic [15:0] r_o
);
    localparam int WIDTH = 16;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           r_state, w_next_state;
    logic [WIDTH-1:0] r_quo, r_rem, r_b_mag, r_a_raw;
    logic [3:0]       r_cnt;
    logic             r_sign_q, r_sign_r, r_div0, r_ovf;
    logic             w_sa, w_sb, w_div0, w_ovf;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_q_fix, w_r_fix;
    logic [WIDTH:0]   w_shift, w_diff;

    assign w_sa    = is_signed_i & a_i[WIDTH-1];
    assign w_sb    = is_signed_i & b_i[WIDTH-1];
    assign w_a_mag = w_sa ? (~a_i + 16'd1) : a_i;
    assign w_b_mag = w_sb ? (~b_i + 16'd1) : b_i;
    assign w_div0  = (b_i == '0);
    assign w_ovf   = is_signed_i & (a_i == 16'h8000) & (b_i == 16'hFFFF);

`ifdef DIV_I16_EARLY_OUT_EN
    logic r_small, w_small, w_early;
    assign w_small = (w_a_mag < w_b_mag);
    assign w_early = w_div0 | w_ovf | w_small;
`endif

    // Partial remainder is < |b| <= 0xFFFF, so the shifted value needs 17 bits.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b_mag};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (data_vld_i) begin
`ifdef DIV_I16_EARLY_OUT_EN
                w_next_state = w_early ? FIX : CALC;
`else
                w_next_state = CALC;
`endif
            end
            CALC: if (r_cnt == 4'd0) w_next_state = FIX;
            FIX:  w_next_state = DONE;
            DONE: if (data_rdy_i) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        data_rdy_o = (r_state == IDLE);
        data_vld_o = (r_state == DONE);
    end

    always_comb begin
        w_q_fix = r_sign_q ? (~r_quo + 16'd1) : r_quo;
        w_r_fix = r_sign_r ? (~r_rem + 16'd1) : r_rem;
        if (r_div0) begin
            w_q_fix = '1;
            w_r_fix = r_a_raw;
        end else if (r_ovf) begin
            w_q_fix = 16'h8000;
            w_r_fix = '0;
        end
`ifdef DIV_I16_EARLY_OUT_EN
        else if (r_small) begin
            w_q_fix = '0;
            w_r_fix = r_a_raw;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_b_mag  <= '0;
            r_a_raw  <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            q_o      <= '0;
            r_o      <= '0;
`ifdef DIV_I16_EARLY_OUT_EN
            r_small  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (data_vld_i) begin
                    r_quo    <= w_a_mag;
                    r_rem    <= '0;
                    r_b_mag  <= w_b_mag;
                    r_a_raw  <= a_i;
                    r_cnt    <= 4'd15;
                    r_sign_q <= w_sa ^ w_sb;
                    r_sign_r <= w_sa;
                    r_div0   <= w_div0;
                    r_ovf    <= w_ovf;
`ifdef DIV_I16_EARLY_OUT_EN
                    r_small  <= w_small;
`endif
                end
                CALC: begin
                    r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
                    r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_cnt <= r_cnt - 4'd1;
                end
                FIX: begin
                    q_o <= w_q_fix;
                    r_o <= w_r_fix;
                end
                default: ;
            endcase
        end
    end
endmodule
